// File: rtl/adsr_pkg.sv
// Shared constants and phase encoding for the adsr envelope controller.
package adsr_pkg;

   localparam int                GAIN_W   = 16;
   localparam logic [GAIN_W-1:0] GAIN_MAX = 16'h7FFF;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_ATTACK  = 3'd1,
      PH_DECAY   = 3'd2,
      PH_SUSTAIN = 3'd3,
      PH_RELEASE = 3'd4
   } phase_t;

   function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] v);
      return (v > GAIN_MAX) ? GAIN_MAX : v;
   endfunction

endpackage

// File: rtl/adsr_ramp_step.sv
// Combinational saturating step of the envelope gain toward a bound, up or down.
// A zero step, overshoot, or borrow lands exactly on the bound and flags it reached.
module adsr_ramp_step
   import adsr_pkg::*;
(
   input  logic [GAIN_W-1:0] i_gain,
   input  logic [GAIN_W-1:0] i_step,
   input  logic [GAIN_W-1:0] i_bound,
   input  logic              i_dir_up,
   output logic [GAIN_W-1:0] o_gain_nxt,
   output logic              o_reached
);

   logic [GAIN_W:0] w_sum;
   logic [GAIN_W:0] w_diff;

   assign w_sum  = {1'b0, i_gain} + {1'b0, i_step};
   assign w_diff = {1'b0, i_gain} - {1'b0, i_step};

   always_comb begin
      o_gain_nxt = i_gain;
      o_reached  = 1'b0;
      if (i_dir_up) begin
         if ((i_step == '0) || (w_sum >= {1'b0, i_bound})) begin
            o_gain_nxt = i_bound;
            o_reached  = 1'b1;
         end else begin
            o_gain_nxt = w_sum[GAIN_W-1:0];
         end
      end else begin
         // w_diff[GAIN_W] is the borrow: the step overshot below zero
         if ((i_step == '0) || w_diff[GAIN_W] || (w_diff[GAIN_W-1:0] <= i_bound)) begin
            o_gain_nxt = i_bound;
            o_reached  = 1'b1;
         end else begin
            o_gain_nxt = w_diff[GAIN_W-1:0];
         end
      end
   end

endmodule

// File: rtl/adsr_env_ctrl.sv
// ADSR envelope sequencer: one gain step per sample strobe, config shadowed at note start.
// Optional exponential release tail when ADSR_ENV_CTRL_EXP_RELEASE_EN is defined.
//
// state      | meaning
// PH_IDLE    | no note; gain held at 0
// PH_ATTACK  | ramp up by attack step toward GAIN_MAX
// PH_DECAY   | ramp down by decay step toward sustain level
// PH_SUSTAIN | hold gain while gate stays high
// PH_RELEASE | ramp down toward 0, then back to idle with note_done
module adsr_env_ctrl
   import adsr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_ready,
   input  logic              gate,
   input  logic              note_start,
   input  logic [GAIN_W-1:0] attack_step,
   input  logic [GAIN_W-1:0] decay_step,
   input  logic [GAIN_W-1:0] sustain_level,
   input  logic [GAIN_W-1:0] release_step,
   output logic [GAIN_W-1:0] gain,
   output logic              gain_valid,
   output logic [2:0]        phase,
   output logic              note_done
);

   phase_t            r_phase;
   logic [GAIN_W-1:0] r_gain;
   logic              r_valid;
   logic              r_done;
   logic [GAIN_W-1:0] r_att;
   logic [GAIN_W-1:0] r_dec;
   logic [GAIN_W-1:0] r_sus;
   logic [GAIN_W-1:0] r_rel;

   phase_t            w_phase_nxt;
   logic [GAIN_W-1:0] w_gain_nxt;
   logic              w_valid_nxt;
   logic              w_done_nxt;
   logic              w_start;
   logic [GAIN_W-1:0] w_rel_step;
   logic [GAIN_W-1:0] w_step;
   logic [GAIN_W-1:0] w_bound;
   logic              w_dir_up;
   logic [GAIN_W-1:0] w_ramp_gain;
   logic              w_ramp_reached;

   assign w_start = note_start & gate;

`ifdef ADSR_ENV_CTRL_EXP_RELEASE_EN
   logic [GAIN_W-1:0] w_shifted;
   logic              w_unused_rel;

   // A floor of 1 guarantees the tail still reaches 0
   assign w_shifted    = r_gain >> r_rel[3:0];
   assign w_rel_step   = (w_shifted == '0) ? {{(GAIN_W-1){1'b0}}, 1'b1} : w_shifted;
   assign w_unused_rel = ^r_rel[GAIN_W-1:4];
`else
   assign w_rel_step = r_rel;
`endif

   always_comb begin
      w_dir_up = 1'b0;
      w_step   = w_rel_step;
      w_bound  = '0;
      case (r_phase)
         PH_ATTACK: begin
            w_dir_up = 1'b1;
            w_step   = r_att;
            w_bound  = GAIN_MAX;
         end
         PH_DECAY: begin
            w_step  = r_dec;
            w_bound = r_sus;
         end
         default: ;
      endcase
   end

   adsr_ramp_step u_ramp (
      .i_gain     (r_gain),
      .i_step     (w_step),
      .i_bound    (w_bound),
      .i_dir_up   (w_dir_up),
      .o_gain_nxt (w_ramp_gain),
      .o_reached  (w_ramp_reached)
   );

   always_comb begin
      w_phase_nxt = r_phase;
      w_gain_nxt  = r_gain;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      if (w_start) begin
         // Legato: keep the current gain, the coincident tick is swallowed
         w_phase_nxt = PH_ATTACK;
      end else if (in_ready) begin
         w_valid_nxt = 1'b1;
         case (r_phase)
            PH_IDLE: begin
               w_gain_nxt = '0;
            end
            PH_ATTACK: begin
               if (!gate) begin
                  w_phase_nxt = PH_RELEASE;
               end else begin
                  w_gain_nxt = w_ramp_gain;
                  if (w_ramp_reached) w_phase_nxt = PH_DECAY;
               end
            end
            PH_DECAY: begin
               if (!gate) begin
                  w_phase_nxt = PH_RELEASE;
               end else begin
                  w_gain_nxt = w_ramp_gain;
                  if (w_ramp_reached) w_phase_nxt = PH_SUSTAIN;
               end
            end
            PH_SUSTAIN: begin
               if (!gate) w_phase_nxt = PH_RELEASE;
            end
            PH_RELEASE: begin
               w_gain_nxt = w_ramp_gain;
               if (w_ramp_reached) begin
                  w_phase_nxt = PH_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               w_phase_nxt = PH_IDLE;
               w_gain_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase <= PH_IDLE;
         r_gain  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_gain  <= w_gain_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_att <= '0;
         r_dec <= '0;
         r_sus <= '0;
         r_rel <= '0;
      end else if (w_start) begin
         r_att <= attack_step;
         r_dec <= decay_step;
         r_sus <= clamp_gain(sustain_level);
         r_rel <= release_step;
      end
   end

   assign gain       = r_gain;
   assign gain_valid = r_valid;
   assign phase      = 3'(r_phase);
   assign note_done  = r_done;

endmodule

// File: tb/tb_adsr_env_ctrl.sv
// Self-checking bench for adsr_env_ctrl: directed scenarios plus randomized run against an integer model.
module tb_adsr_env_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_ready;
   logic        gate;
   logic        note_start;
   logic [15:0] attack_step;
   logic [15:0] decay_step;
   logic [15:0] sustain_level;
   logic [15:0] release_step;
   logic [15:0] gain;
   logic        gain_valid;
   logic [2:0]  phase;
   logic        note_done;

   int n_cmp = 0;
   int n_err = 0;

   int m_phase, m_gain, m_att, m_dec, m_sus, m_rel;
   bit m_valid, m_done;

`ifdef ADSR_ENV_CTRL_EXP_RELEASE_EN
   localparam logic [15:0] LEG_REL  = 16'h0001;
   localparam logic [15:0] LEG_GAIN = 16'h2800;
`else
   localparam logic [15:0] LEG_REL  = 16'h2000;
   localparam logic [15:0] LEG_GAIN = 16'h3000;
`endif

   always #5 clk = ~clk;

   adsr_env_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .in_ready      (in_ready),
      .gate          (gate),
      .note_start    (note_start),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .sustain_level (sustain_level),
      .release_step  (release_step),
      .gain          (gain),
      .gain_valid    (gain_valid),
      .phase         (phase),
      .note_done     (note_done)
   );

   function automatic void model_reset();
      m_phase = 0; m_gain = 0; m_att = 0; m_dec = 0; m_sus = 0; m_rel = 0;
      m_valid = 0; m_done = 0;
   endfunction

   // Envelope rules in plain integer arithmetic
   function automatic void model_step(input bit ns, input bit rdy, input bit g);
      int nxt;
      int st;
      m_valid = 0;
      m_done  = 0;
      if (ns && g) begin
         m_phase = 1;
         m_att   = {16'h0, attack_step};
         m_dec   = {16'h0, decay_step};
         m_sus   = (sustain_level > 16'h7FFF) ? 32767 : {16'h0, sustain_level};
         m_rel   = {16'h0, release_step};
      end else if (rdy) begin
         m_valid = 1;
         case (m_phase)
            0: m_gain = 0;
            1: if (!g) m_phase = 4;
               else begin
                  nxt = m_gain + m_att;
                  if (m_att == 0 || nxt >= 32767) begin m_gain = 32767; m_phase = 2; end
                  else m_gain = nxt;
               end
            2: if (!g) m_phase = 4;
               else begin
                  nxt = m_gain - m_dec;
                  if (m_dec == 0 || nxt <= m_sus) begin m_gain = m_sus; m_phase = 3; end
                  else m_gain = nxt;
               end
            3: if (!g) m_phase = 4;
            4: begin
`ifdef ADSR_ENV_CTRL_EXP_RELEASE_EN
               st = m_gain >> (m_rel % 16);
               if (st < 1) st = 1;
`else
               st = m_rel;
`endif
               nxt = m_gain - st;
               if (st == 0 || nxt <= 0) begin m_gain = 0; m_phase = 0; m_done = 1; end
               else m_gain = nxt;
            end
            default: ;
         endcase
      end
   endfunction

   task automatic do_cycle(input logic ns, input logic rdy, input logic g);
      @(negedge clk);
      note_start = ns;
      in_ready   = rdy;
      gate       = g;
      @(posedge clk);
      model_step(ns, rdy, g);
      #1;
   endtask

   task automatic idle(input int n, input logic g);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, g);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_ready = 0; gate = 0; note_start = 0;
      attack_step = 0; decay_step = 0; sustain_level = 0; release_step = 0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (gain !== 16'h0) begin n_err++; $display("FAIL reset_gain got=%h exp=0000", gain); end
      n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase got=%0d exp=0", phase); end
      n_cmp++; if (gain_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", gain_valid); end
      n_cmp++; if (note_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", note_done); end
      reset = 1'b1;
      idle(2, 1'b0);
   endtask

   task automatic test_attack_decay();
      logic [15:0] exp_att [4] = '{16'h2000, 16'h4000, 16'h6000, 16'h7FFF};
      logic [15:0] exp_dec [4] = '{16'h6FFF, 16'h5FFF, 16'h4FFF, 16'h4000};
      attack_step = 16'h2000; decay_step = 16'h1000;
      sustain_level = 16'h4000; release_step = 16'h4000;
      do_cycle(1'b1, 1'b0, 1'b1);
      n_cmp++; if (phase !== 3'd1 || gain !== 16'h0) begin n_err++; $display("FAIL ad_start got phase=%0d gain=%h exp phase=1 gain=0000", phase, gain); end
      for (int i = 0; i < 8; i++) begin
         logic [15:0] e;
         e = (i < 4) ? exp_att[i] : exp_dec[i-4];
         do_cycle(1'b0, 1'b1, 1'b1);
         n_cmp++; if (gain !== e || gain_valid !== 1'b1) begin n_err++; $display("FAIL ad_tick%0d got gain=%h valid=%b exp gain=%h valid=1", i, gain, gain_valid, e); end
         do_cycle(1'b0, 1'b0, 1'b1);
         n_cmp++; if (gain_valid !== 1'b0) begin n_err++; $display("FAIL ad_valid_width%0d got=%b exp=0", i, gain_valid); end
         if (i == 3) begin
            n_cmp++; if (phase !== 3'd2) begin n_err++; $display("FAIL ad_to_decay got=%0d exp=2", phase); end
         end
         idle(48, 1'b1);
      end
      n_cmp++; if (phase !== 3'd3) begin n_err++; $display("FAIL ad_to_sustain got=%0d exp=3", phase); end
   endtask

   task automatic test_release();
      do_cycle(1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (phase !== 3'd4 || gain !== 16'h4000 || note_done !== 1'b0) begin n_err++; $display("FAIL rel_enter got phase=%0d gain=%h done=%b exp phase=4 gain=4000 done=0", phase, gain, note_done); end
      do_cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (phase !== 3'd0 || gain !== 16'h0 || note_done !== 1'b1 || gain_valid !== 1'b1) begin n_err++; $display("FAIL rel_end got phase=%0d gain=%h done=%b valid=%b exp phase=0 gain=0000 done=1 valid=1", phase, gain, note_done, gain_valid); end
      do_cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (note_done !== 1'b0 || gain !== 16'h0 || phase !== 3'd0 || gain_valid !== 1'b1) begin n_err++; $display("FAIL rel_idle_tick got done=%b gain=%h phase=%0d valid=%b exp done=0 gain=0000 phase=0 valid=1", note_done, gain, phase, gain_valid); end
   endtask

   task automatic test_legato();
      logic [15:0] e;
      attack_step = 16'h2000; decay_step = 16'h1000;
      sustain_level = 16'h5000; release_step = LEG_REL;
      do_cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         do_cycle(1'b0, 1'b1, 1'b1);
         idle(2, 1'b1);
      end
      n_cmp++; if (phase !== 3'd3 || gain !== 16'h5000) begin n_err++; $display("FAIL leg_sustain got phase=%0d gain=%h exp phase=3 gain=5000", phase, gain); end
      do_cycle(1'b0, 1'b1, 1'b0);
      do_cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (phase !== 3'd4 || gain !== LEG_GAIN) begin n_err++; $display("FAIL leg_release got phase=%0d gain=%h exp phase=4 gain=%h", phase, gain, LEG_GAIN); end
      do_cycle(1'b1, 1'b1, 1'b1);
      n_cmp++; if (phase !== 3'd1 || gain !== LEG_GAIN || gain_valid !== 1'b0) begin n_err++; $display("FAIL leg_retrig got phase=%0d gain=%h valid=%b exp phase=1 gain=%h valid=0", phase, gain, gain_valid, LEG_GAIN); end
      e = LEG_GAIN + 16'h2000;
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (phase !== 3'd1 || gain !== e) begin n_err++; $display("FAIL leg_step got phase=%0d gain=%h exp phase=1 gain=%h", phase, gain, e); end
   endtask

   task automatic test_zero_steps();
      attack_step = 16'h0; decay_step = 16'h0; sustain_level = 16'h2345;
      do_cycle(1'b1, 1'b0, 1'b1);
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (gain !== 16'h7FFF || phase !== 3'd2) begin n_err++; $display("FAIL zero_attack got gain=%h phase=%0d exp gain=7fff phase=2", gain, phase); end
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (gain !== 16'h2345 || phase !== 3'd3) begin n_err++; $display("FAIL zero_decay got gain=%h phase=%0d exp gain=2345 phase=3", gain, phase); end
   endtask

   task automatic test_async_reset();
      attack_step = 16'h1000;
      do_cycle(1'b1, 1'b0, 1'b1);
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (gain !== 16'h3345 || phase !== 3'd1) begin n_err++; $display("FAIL ar_pre got gain=%h phase=%0d exp gain=3345 phase=1", gain, phase); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (gain !== 16'h0 || phase !== 3'd0 || gain_valid !== 1'b0) begin n_err++; $display("FAIL ar_now got gain=%h phase=%0d valid=%b exp gain=0000 phase=0 valid=0", gain, phase, gain_valid); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         do_cycle(1'b0, 1'b1, 1'b1);
         n_cmp++; if (gain !== 16'h0 || phase !== 3'd0 || gain_valid !== 1'b1) begin n_err++; $display("FAIL ar_after%0d got gain=%h phase=%0d valid=%b exp gain=0000 phase=0 valid=1", i, gain, phase, gain_valid); end
      end
   endtask

   task automatic test_shadow();
      attack_step = 16'h1000; sustain_level = 16'h7000;
      do_cycle(1'b1, 1'b0, 1'b0);
      n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL sh_ignored got phase=%0d exp=0", phase); end
      do_cycle(1'b1, 1'b0, 1'b1);
      attack_step = 16'h3000;
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (gain !== 16'h1000) begin n_err++; $display("FAIL sh_tick1 got=%h exp=1000", gain); end
      do_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (gain !== 16'h2000) begin n_err++; $display("FAIL sh_tick2 got=%h exp=2000", gain); end
   endtask

   function automatic logic [15:0] pick_step();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 16'h0;
      if (r == 1) return 16'($urandom);
      return 16'($urandom_range(1, 16'h1800));
   endfunction

   task automatic test_random();
      logic ns, rdy, g;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      g = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 8 == 0) begin
            attack_step   = pick_step();
            decay_step    = pick_step();
            release_step  = pick_step();
            sustain_level = 16'($urandom);
         end
         ns  = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) g = ~g;
         do_cycle(ns, rdy, g);
         n_cmp++; if (gain !== m_gain[15:0]) begin n_err++; $display("FAIL rnd_gain cyc=%0d got=%h exp=%h", i, gain, m_gain[15:0]); end
         n_cmp++; if (phase !== m_phase[2:0]) begin n_err++; $display("FAIL rnd_phase cyc=%0d got=%0d exp=%0d", i, phase, m_phase); end
         n_cmp++; if (gain_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, gain_valid, m_valid); end
         n_cmp++; if (note_done !== m_done) begin n_err++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, note_done, m_done); end
      end
   endtask

   initial begin
      test_reset();
      test_attack_decay();
      test_release();
      test_legato();
      test_zero_steps();
      test_async_reset();
      test_shadow();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adsr_env_ctrl.md
Name: adsr_env_ctrl

Overview:
- Envelope sequencer for the adsr amplitude datapath.
- Runs the attack/decay/sustain/release state machine from a note gate and retrigger pulse, advancing one step per sample strobe (in_ready).
- Presents a 16-bit gain word, plus a one-cycle valid, that the adsr multiplier applies to the next sample.
- Sits between the note sequencer (gate, note start, envelope config) and the adsr sample path.

Parameters:
- GAIN_W, 16, width of gain and step words (unsigned).
- GAIN_MAX, 16'h7FFF, full-scale gain; matches positive full-scale sample.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_ready  in  1  sample strobe; one envelope step per high cycle
- gate  in  1  note held (level)
- note_start  in  1  one-cycle pulse, start/retrigger note; honoured only when gate=1
- attack_step  in  GAIN_W  gain increment per tick in ATTACK
- decay_step  in  GAIN_W  gain decrement per tick in DECAY
- sustain_level  in  GAIN_W  DECAY target/SUSTAIN hold value; clamped to GAIN_MAX
- release_step  in  GAIN_W  gain decrement per tick in RELEASE (shift amount in low 4 bits when the optional feature is on)
- gain  out  GAIN_W  current envelope gain
- gain_valid  out  1  one-cycle pulse; gain updated for this sample
- phase  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- note_done  out  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset (reset=0, async): gain=0, phase=IDLE, gain_valid=0, note_done=0, shadow config=0. Release of reset is synchronous to clk.
- Config shadowing:
  - The four config inputs are latched into shadow registers on an accepted note_start.
  - Config changes mid-note have no effect.
- note_start acceptance:
  - Accepted when note_start=1 and gate=1, any state.
  - Next cycle: phase=ATTACK, gain unchanged (legato retrigger, no click).
  - Accepted note_start takes priority over an in_ready in the same cycle; that tick is consumed without a step.
- Tick (in_ready=1, no accepted note_start): gain and phase update at the next edge; gain_valid=1 that same cycle (latency 1). Per state:
  - IDLE: gain held at 0; gain_valid still pulses.
  - ATTACK:
    - If gate=0, go to RELEASE; no attack step.
    - Otherwise gain = min(gain+attack_step, GAIN_MAX), using a 17-bit sum so there is no wrap.
    - On reaching GAIN_MAX, go to DECAY.
    - attack_step=0 jumps to GAIN_MAX on that tick.
  - DECAY:
    - If gate=0, go to RELEASE.
    - Otherwise gain = max(gain−decay_step, sustain_level).
    - On reaching sustain_level, go to SUSTAIN.
    - decay_step=0 jumps to sustain_level.
  - SUSTAIN: gain holds; if gate=0, go to RELEASE.
  - RELEASE:
    - gain = max(gain−release_step, 0); borrow is detected, no wrap.
    - On reaching 0, go to IDLE and pulse note_done coincident with that gain_valid.
    - release_step=0 jumps to 0.
- gate falling outside a tick takes effect at the next tick.
- gate=0 in IDLE or RELEASE: no effect.
- gate=0 with note_start: the pulse is ignored.
- No tick means no state or gain change, apart from note_start acceptance.

Optional Feature:
- Macro ADSR_ENV_CTRL_EXP_RELEASE_EN.
- Defined: RELEASE step is gain − max(gain >> release_step[3:0], 1), giving an exponential tail that still terminates at 0.
- Undefined: linear RELEASE as above; release_step used in full.

Decomposition:
- Package adsr_pkg holds:
  - phase encodings (IDLE..RELEASE)
  - GAIN_MAX
  - GAIN_W
- One sub-module, adsr_ramp_step: combinational saturating add/subtract toward a bound. Inputs are gain, step, bound and direction; outputs are the next gain and a reached flag. It is instantiated once and muxed by phase.

Test Plan:
- Attack/decay: gate=1, note_start; attack_step=0x2000, decay_step=0x1000, sustain_level=0x4000; ticks every 50 clk.
  - Attack gains: 0x2000, 0x4000, 0x6000, 0x7FFF (phase→DECAY).
  - Decay gains: 0x6FFF, 0x5FFF, 0x4FFF, 0x4000 (phase→SUSTAIN).
  - gain_valid is exactly 1 cycle after each in_ready.
- Release: from SUSTAIN 0x4000, drop gate, release_step=0x4000 → next tick gain=0, phase=IDLE, note_done pulses once with gain_valid.
- Legato retrigger: in RELEASE at gain 0x3000, note_start with gate=1 → phase=ATTACK, gain stays 0x3000, next tick 0x5000 (attack_step=0x2000).
- Zero steps: attack_step=0, decay_step=0 → gain hits 0x7FFF on tick 1, sustain_level on tick 2.
- Async reset mid-ATTACK: reset low between clock edges → gain=0, phase=IDLE immediately. After release, ticks hold gain 0 until note_start.
- Config shadow and ignored start: change attack_step mid-attack → step unchanged. note_start with gate=0 → remains IDLE.
